inst_loader: RTL and testbench

Boot-time writer for the processor's 64×16 instruction memory. It receives a framed byte stream over a valid/ready handshake, assembles big-endian 16-bit words, writes them sequentially from address 0, and verifies an XOR checksum. It holds the processor (`cpu_hold`) from reset until a frame loads cleanly, then releases it so fetch starts at PC 0.

---
 rtl/inst_loader.sv | 182 ++++++++++++++++++
 tb/tb_inst_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - boot-time framed byte-stream loader for the 64x16 instruction memory
//
// Accepts a frame (SYNC, count N, N big-endian 16-bit words, XOR checksum)
// over a valid/ready byte stream, writes the words from address 0 and holds
// the processor until a frame loads with a matching checksum.
//
// Ports:
//   clk       - single clock, all state changes on posedge
//   clear     - asynchronous active-low reset
//   in_data   - incoming byte
//   in_valid  - in_data is valid
//   in_ready  - loader accepts the byte this cycle (registered)
//   wr_en     - instruction-memory write strobe, one cycle per word
//   wr_addr   - instruction-memory write address
//   wr_data   - instruction-memory write data
//   cpu_hold  - stalls the processor while high
//   done      - last frame loaded and its checksum matched
//   err       - last frame was rejected
module inst_loader #(
    parameter int           DEPTH  = 64,
    parameter int           ADDR_W = 6,
    parameter logic [7:0]   SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_CHK   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [6:0]        remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;

    // in_ready is a flop, so the handshake never depends combinationally on in_valid
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept && in_data == SYNC) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (accept) begin
                    if (in_data == 8'd0 || {1'b0, in_data} > DEPTH_L) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        remaining_d = in_data[6:0];
                        csum_d      = 8'd0;
                        addr_d      = '0;
                        state_d     = S_HI;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    csum_d    = csum_q ^ in_data;
                    wr_data_d = {hi_q, in_data};
                    wr_en_d   = 1'b1;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                // wr_addr shows addr_q during this cycle; advance for the next word
                addr_d      = addr_q + ADDR_W'(1);
                remaining_d = remaining_q - 7'd1;
                state_d     = (remaining_q == 7'd1) ? S_CHK : S_HI;
            end
            S_CHK: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (accept && in_data == SYNC) begin
                    state_d    = S_COUNT;
                    done_d     = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
            S_ERR: begin
                if (accept && in_data == SYNC) begin
                    state_d = S_COUNT;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Decoded from the next state so in_ready is low exactly while in WR
        in_ready_d = (state_d != S_WR);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= S_IDLE;
            remaining_q <= 7'd0;
            addr_q      <= '0;
            hi_q        <= 8'd0;
            csum_q      <= 8'd0;
            wr_data_q   <= 16'd0;
            wr_en_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            hi_q        <= hi_d;
            csum_q      <= csum_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            in_ready_q  <= in_ready_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - self-checking bench for inst_loader
module tb_inst_loader;

    logic        clk;
    logic        clear;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx[$];
    logic [5:0]  log_addr[$];
    logic [15:0] log_data[$];

    inst_loader dut (
        .clk      (clk),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Record every write strobe; a byte must never be acceptable during a write cycle
    always @(negedge clk) begin
        if (clear && wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            check("ready_low_in_wr", 32'(in_ready), 32'd0);
        end
    end

    // Sends tx[] one byte at a time; each call returns at a negedge just after
    // the edge that accepted its last byte. With gaps, idle cycles carry SYNC
    // on in_data with in_valid low, which must have no effect.
    task automatic send_frame(input bit gaps);
        logic rdy;
        bit   ok;
        foreach (tx[i]) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'hA5;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = tx[i];
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                rdy = in_ready;
                @(negedge clk);
                if (rdy) ok = 1'b1;
            end
            if (!ok) check("byte_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_wr_en"},    32'(wr_en),    32'd0);
        check({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
        check({tag, "_wr_data"},  32'(wr_data),  32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
    endtask

    initial begin
        logic [7:0] hi, lo, cs;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset values
        @(negedge clk);
        check_reset_outputs("reset");
        clear = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(in_ready), 32'd1);

        // Good frame: checksum 12^34^AB^CD = 40
        log_addr.delete(); log_data.delete();
        tx = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_frame(1'b0);
        check("good_done", 32'(done), 32'd1);
        check("good_hold", 32'(cpu_hold), 32'd0);
        check("good_err", 32'(err), 32'd0);
        check("good_nwr", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            check("good_a0", 32'(log_addr[0]), 32'd0);
            check("good_d0", 32'(log_data[0]), 32'h1234);
            check("good_a1", 32'(log_addr[1]), 32'd1);
            check("good_d1", 32'(log_data[1]), 32'hABCD);
        end

        // Bad checksum: one write, then rejection
        log_addr.delete(); log_data.delete();
        tx = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'h00};
        send_frame(1'b0);
        check("bad_err", 32'(err), 32'd1);
        check("bad_hold", 32'(cpu_hold), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_nwr", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) begin
            check("bad_a0", 32'(log_addr[0]), 32'd0);
            check("bad_d0", 32'(log_data[0]), 32'h0007);
        end

        // Count zero
        log_addr.delete(); log_data.delete();
        tx = '{8'hA5};
        send_frame(1'b0);
        check("sync_clears_err", 32'(err), 32'd0);
        tx = '{8'h00};
        send_frame(1'b0);
        check("n0_err", 32'(err), 32'd1);
        check("n0_nwr", log_addr.size(), 32'd0);

        // Count 65
        tx = '{8'hA5, 8'h41};
        send_frame(1'b0);
        repeat (3) @(negedge clk);
        check("n65_err", 32'(err), 32'd1);
        check("n65_done", 32'(done), 32'd0);
        check("n65_nwr", log_addr.size(), 32'd0);

        // Count 64: full memory
        log_addr.delete(); log_data.delete();
        tx = '{8'hA5, 8'h40};
        cs = 8'h00;
        for (int i = 0; i < 64; i++) begin
            hi = 8'(i);
            lo = 8'(i) ^ 8'h3C;
            tx.push_back(hi);
            tx.push_back(lo);
            cs = cs ^ hi ^ lo;
        end
        tx.push_back(cs);
        send_frame(1'b0);
        check("n64_done", 32'(done), 32'd1);
        check("n64_err", 32'(err), 32'd0);
        check("n64_nwr", log_addr.size(), 32'd64);
        if (log_addr.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                hi = 8'(i);
                lo = 8'(i) ^ 8'h3C;
                check("n64_addr", 32'(log_addr[i]), 32'(i));
                check("n64_data", 32'(log_data[i]), {16'd0, hi, lo});
            end
        end

        // Reset mid-frame, with a write strobe in progress
        tx = '{8'hA5, 8'h02, 8'h12, 8'h34};
        send_frame(1'b0);
        check("mid_wr_active", 32'(wr_en), 32'd1);
        clear = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        check("mid_ready_after", 32'(in_ready), 32'd1);
        log_addr.delete(); log_data.delete();
        tx = '{8'hA5, 8'h01, 8'h5A, 8'h5A, 8'h00};
        send_frame(1'b0);
        check("mid_done", 32'(done), 32'd1);
        check("mid_nwr", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) begin
            check("mid_a0", 32'(log_addr[0]), 32'd0);
            check("mid_d0", 32'(log_data[0]), 32'h5A5A);
        end

        // Handshake gaps and leading garbage from IDLE
        do_reset();
        log_addr.delete(); log_data.delete();
        tx = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_frame(1'b1);
        check("gap_done", 32'(done), 32'd1);
        check("gap_hold", 32'(cpu_hold), 32'd0);
        check("gap_nwr", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            check("gap_a0", 32'(log_addr[0]), 32'd0);
            check("gap_d0", 32'(log_data[0]), 32'h1234);
            check("gap_a1", 32'(log_addr[1]), 32'd1);
            check("gap_d1", 32'(log_data[1]), 32'hABCD);
        end

        // Reload from DONE
        log_addr.delete(); log_data.delete();
        tx = '{8'hA5};
        send_frame(1'b0);
        check("reload_done_drop", 32'(done), 32'd0);
        check("reload_hold_rise", 32'(cpu_hold), 32'd1);
        tx = '{8'h01, 8'hFF, 8'hFF, 8'h00};
        send_frame(1'b0);
        check("reload_done", 32'(done), 32'd1);
        check("reload_nwr", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) begin
            check("reload_a0", 32'(log_addr[0]), 32'd0);
            check("reload_d0", 32'(log_data[0]), 32'hFFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
